qval_writeback: RTL and testbench

- Terminating end of the Q-update pipeline: consumes the 24-bit updated-Q `sum` stream produced by `pipeline`, tagged with its Q-table address.
- Converts each value to the Q-table storage format: arithmetic shift plus saturation to 16 bits.
- Buffers up to DEPTH pending updates and writes them into the shared Q-table BRAM port through a request/grant handshake.
- Exposes an address-hazard probe so the upstream issuer can stall read-after-write conflicts on not-yet-committed entries.

---
 rtl/qlearn_pkg.sv | 33 +++
 rtl/qval_writeback_fifo.sv | 71 +++++++
 rtl/qval_writeback.sv | 130 +++++++++++++
 tb/tb_qval_writeback.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared Q-learning fixed-point definitions: Q-table formats, saturation bounds and the
// accumulator-to-storage conversion. Rounding is selected by the QWB_ROUND_EN macro.
package qlearn_pkg;

  localparam int IN_W       = 24;
  localparam int Q_W        = 16;
  localparam int ADDR_W     = 10;
  localparam int FRAC_SHIFT = 4;
  localparam int QWB_DEPTH  = 4;

  localparam logic [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

  typedef enum logic {WB_IDLE, WB_REQ} wb_state_e;

  // One guard bit above IN_W keeps the rounding add from wrapping before saturation.
  function automatic logic [Q_W-1:0] q_convert(input logic [IN_W-1:0] sum);
    logic signed [IN_W:0] x;
    logic signed [IN_W:0] hi;
    logic signed [IN_W:0] lo;
    hi = {{(IN_W+1-Q_W){Q_MAX[Q_W-1]}}, Q_MAX};
    lo = {{(IN_W+1-Q_W){Q_MIN[Q_W-1]}}, Q_MIN};
    x  = signed'({sum[IN_W-1], sum});
`ifdef QWB_ROUND_EN
    x = x + signed'((IN_W+1)'(1) << (FRAC_SHIFT - 1));
`endif
    x = x >>> FRAC_SHIFT;
    if (x > hi) return Q_MAX;
    if (x < lo) return Q_MIN;
    return x[Q_W-1:0];
  endfunction

endpackage

// File: rtl/qval_writeback_fifo.sv
// qwb_fifo: register FIFO of pending {addr, data} updates. Exposes the head, the entry
// behind it, and every slot's address/valid so the top can run the hazard compare.
module qwb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data,
  output logic [AW-1:0]             next_addr,
  output logic [DW-1:0]             next_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [AW-1:0]             entry_addr [DEPTH],
  output logic [DEPTH-1:0]          entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_next;

  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  // full is registered from the next occupancy so in_ready never sees push/valid combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  assign empty      = (count == '0);
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign next_addr  = addr_mem[rd_ptr + PW'(1)];
  assign next_data  = data_mem[rd_ptr + PW'(1)];
  assign entry_addr = addr_mem;

  always_comb begin
    logic [PW-1:0] off;
    off         = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/qval_writeback.sv
// qval_writeback: converts pipeline sums to Q-table format, queues them and commits them to
// the BRAM port via req/gnt. Build with QWB_ROUND_EN for round-half-up conversion.
module qval_writeback
  import qlearn_pkg::*;
#(
  parameter int DEPTH = QWB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_sum,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [Q_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0] probe_addr,
  output logic              probe_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic [15:0]       wr_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e         state, state_next;
  logic              accept, pop, load;
  logic              fifo_full, fifo_empty, flush_pending;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W-1:0] head_addr, next_addr, load_addr;
  logic [Q_W-1:0]    head_data, next_data, load_data, conv_data;
  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DEPTH-1:0]  entry_valid, entry_match;

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign conv_data = q_convert(in_sum);
  assign wr_req    = (state == WB_REQ);
  assign pop       = (state == WB_REQ) && wr_gnt;

  // The presented write stays in the FIFO until granted, so DEPTH bounds all uncommitted updates.
  qwb_fifo #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(Q_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .pop        (pop),
    .push_addr  (in_addr),
    .push_data  (conv_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .next_addr  (next_addr),
    .next_data  (next_data),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_addr (entry_addr),
    .entry_valid(entry_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WB_IDLE;
    else        state <= state_next;
  end

  // Output registers always mirror the FIFO head; an empty FIFO forwards the accepting input.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_addr  = head_addr;
    load_data  = head_data;
    unique case (state)
      WB_IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = WB_REQ;
        end else if (accept) begin
          load       = 1'b1;
          load_addr  = in_addr;
          load_data  = conv_data;
          state_next = WB_REQ;
        end
      end
      WB_REQ: begin
        if (wr_gnt) begin
          if (fifo_count >= CW'(2)) begin
            load      = 1'b1;
            load_addr = next_addr;
            load_data = next_data;
          end else if (accept) begin
            load      = 1'b1;
            load_addr = in_addr;
            load_data = conv_data;
          end else begin
            state_next = WB_IDLE;
          end
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_count      <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (load) begin
        wr_addr <= load_addr;
        wr_data <= load_data;
      end
      if (pop) wr_count <= wr_count + 16'd1;
      flush_pending <= flush || (flush_pending && !flush_done);
    end
  end

  assign flush_done = flush_pending && fifo_empty && (state == WB_IDLE) && !accept;

  always_comb begin
    entry_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_match[i] = entry_valid[i] && (entry_addr[i] == probe_addr);
    end
  end

  assign probe_hit = (|entry_match) || (wr_req && (wr_addr == probe_addr));

endmodule

// File: tb/tb_qval_writeback.sv
// Directed self-checking bench for qval_writeback: conversion, latency, backpressure,
// hazard probe, flush and reset behaviour with hand-computed expectations.
module tb_qval_writeback;
  import qlearn_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, wr_gnt, flush;
  logic [IN_W-1:0]   in_sum;
  logic [ADDR_W-1:0] in_addr, probe_addr;
  logic              in_ready, wr_req, probe_hit, flush_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [Q_W-1:0]    wr_data;
  logic [15:0]       wr_count;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  qval_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_addr   (in_addr),
    .wr_req    (wr_req),
    .wr_gnt    (wr_gnt),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .probe_addr(probe_addr),
    .probe_hit (probe_hit),
    .flush     (flush),
    .flush_done(flush_done),
    .wr_count  (wr_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; wr_gnt = 1'b0; flush = 1'b0;
    in_sum = '0; in_addr = '0; probe_addr = '0;
    step(); step();
    checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_req got=%0h exp=0", wr_req); end
    checks++; if (wr_addr !== '0) begin failures++; $display("[TB] FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wr_data !== '0) begin failures++; $display("[TB] FAIL reset_wr_data got=%0h exp=0", wr_data); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_done got=%0h exp=0", flush_done); end
    checks++; if (wr_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_wr_count got=%0h exp=0", wr_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0h exp=1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_update();
    wr_gnt = 1'b1; in_valid = 1'b1; in_sum = 24'h000120; in_addr = 10'd5;
    #1;
    checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL single_pre_req got=%0h exp=0", wr_req); end
    step();
    in_valid = 1'b0;
    checks++; if (wr_req !== 1'b1) begin failures++; $display("[TB] FAIL single_req got=%0h exp=1", wr_req); end
    checks++; if (wr_addr !== 10'd5) begin failures++; $display("[TB] FAIL single_addr got=%0h exp=5", wr_addr); end
    checks++; if (wr_data !== 16'h0012) begin failures++; $display("[TB] FAIL single_data got=%0h exp=0012", wr_data); end
    step();
    exp_count = exp_count + 16'd1;
    checks++; if (wr_count !== exp_count) begin failures++; $display("[TB] FAIL single_count got=%0h exp=%0h", wr_count, exp_count); end
    checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL single_req_drop got=%0h exp=0", wr_req); end
  endtask

  task automatic test_saturation();
    logic [23:0] sums [9];
    logic [15:0] exps [9];
    sums = '{24'h7FFFF0, 24'h800000, 24'hFF0000, 24'h000018, 24'h7FFFFF,
             24'hFFFFF8, 24'h07FFF0, 24'hF80000, 24'hF7FFF0};
`ifdef QWB_ROUND_EN
    exps = '{16'h7FFF, 16'h8000, 16'hF000, 16'h0002, 16'h7FFF,
             16'h0000, 16'h7FFF, 16'h8000, 16'h8000};
`else
    exps = '{16'h7FFF, 16'h8000, 16'hF000, 16'h0001, 16'h7FFF,
             16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
`endif
    wr_gnt = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_sum = sums[i]; in_addr = ADDR_W'(i + 8);
      step();
      in_valid = 1'b0;
      checks++;
      if (wr_req !== 1'b1 || wr_data !== exps[i]) begin
        failures++;
        $display("[TB] FAIL convert[%0d] sum=%h req=%0h got=%h exp=%h", i, sums[i], wr_req, wr_data, exps[i]);
      end
      step();
      exp_count = exp_count + 16'd1;
    end
    checks++; if (wr_count !== exp_count) begin failures++; $display("[TB] FAIL convert_count got=%0h exp=%0h", wr_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(16 + i); in_sum = 24'h001000 + 24'(i * 16);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%0h exp=1", i, in_ready); end
      step();
    end
    in_addr = 10'h14; in_sum = 24'h001040;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0 || wr_req !== 1'b1 || wr_addr !== 10'h10 || wr_data !== 16'h0100) begin
        failures++;
        $display("[TB] FAIL bp_hold[%0d] ready=%0h req=%0h addr=%h data=%h exp ready=0 req=1 addr=010 data=0100",
                 k, in_ready, wr_req, wr_addr, wr_data);
      end
      step();
    end
    in_valid = 1'b0; wr_gnt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (wr_req !== 1'b1 || wr_addr !== ADDR_W'(16 + j) || wr_data !== Q_W'(256 + j)) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] req=%0h addr=%h data=%h exp addr=%h data=%h",
                 j, wr_req, wr_addr, wr_data, ADDR_W'(16 + j), Q_W'(256 + j));
      end
      step();
    end
    exp_count = exp_count + 16'd4;
    checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%0h exp=0", wr_req); end
    checks++; if (wr_count !== exp_count) begin failures++; $display("[TB] FAIL b2b_count got=%0h exp=%0h", wr_count, exp_count); end
  endtask

  task automatic test_hazard();
    wr_gnt = 1'b0;
    in_valid = 1'b1; in_addr = 10'h03A; in_sum = 24'h000010; step();
    in_addr = 10'h03C; in_sum = 24'h000020; step();
    in_valid = 1'b0;
    probe_addr = 10'h03A; #1;
    checks++; if (probe_hit !== 1'b1) begin failures++; $display("[TB] FAIL hz_head got=%0h exp=1", probe_hit); end
    probe_addr = 10'h03C; #1;
    checks++; if (probe_hit !== 1'b1) begin failures++; $display("[TB] FAIL hz_queued got=%0h exp=1", probe_hit); end
    probe_addr = 10'h03B; #1;
    checks++; if (probe_hit !== 1'b0) begin failures++; $display("[TB] FAIL hz_miss got=%0h exp=0", probe_hit); end
    probe_addr = 10'h03A; wr_gnt = 1'b1;
    step();
    wr_gnt = 1'b0;
    checks++; if (probe_hit !== 1'b0) begin failures++; $display("[TB] FAIL hz_committed got=%0h exp=0", probe_hit); end
    checks++; if (wr_addr !== 10'h03C) begin failures++; $display("[TB] FAIL hz_next_addr got=%h exp=03c", wr_addr); end
    probe_addr = 10'h03C; #1;
    checks++; if (probe_hit !== 1'b1) begin failures++; $display("[TB] FAIL hz_pending got=%0h exp=1", probe_hit); end
    wr_gnt = 1'b1;
    step();
    wr_gnt = 1'b0;
    exp_count = exp_count + 16'd2;
    checks++; if (probe_hit !== 1'b0 || wr_req !== 1'b0) begin failures++; $display("[TB] FAIL hz_drained hit=%0h req=%0h exp 0 0", probe_hit, wr_req); end
  endtask

  task automatic test_flush();
    int pulses;
    logic [15:0] count_at_done;
    pulses = 0; count_at_done = 16'hDEAD;
    wr_gnt = 1'b0;
    in_valid = 1'b1; in_addr = 10'h050; in_sum = 24'h000030; step();
    in_addr = 10'h051; step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (flush_done !== 1'b0) begin failures++; $display("[TB] FAIL flush_early got=%0h exp=0", flush_done); end
    wr_gnt = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (flush_done === 1'b1) begin
        if (pulses == 0) count_at_done = wr_count;
        pulses++;
      end
      step();
    end
    exp_count = exp_count + 16'd2;
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL flush_pulses got=%0d exp=1", pulses); end
    checks++; if (count_at_done !== exp_count) begin failures++; $display("[TB] FAIL flush_after_drain got=%0h exp=%0h", count_at_done, exp_count); end
  endtask

  task automatic test_reset_mid();
    wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(96 + i); in_sum = 24'h000040;
      step();
    end
    in_valid = 1'b0;
    checks++; if (wr_req !== 1'b1) begin failures++; $display("[TB] FAIL rm_pending got=%0h exp=1", wr_req); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 16'd0;
    checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL rm_req got=%0h exp=0", wr_req); end
    checks++; if (wr_count !== 16'd0) begin failures++; $display("[TB] FAIL rm_count got=%0h exp=0", wr_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_ready got=%0h exp=1", in_ready); end
    checks++; if (wr_addr !== '0 || wr_data !== '0) begin failures++; $display("[TB] FAIL rm_outputs addr=%h data=%h exp 0 0", wr_addr, wr_data); end
    wr_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL rm_no_write[%0d] got=%0h exp=0", c, wr_req); end
      step();
    end
    checks++; if (wr_count !== exp_count) begin failures++; $display("[TB] FAIL rm_count_hold got=%0h exp=%0h", wr_count, exp_count); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1) begin failures++; $display("[TB] FAIL rm_flush_done got=%0h exp=1", flush_done); end
    step();
    checks++; if (flush_done !== 1'b0) begin failures++; $display("[TB] FAIL rm_flush_pulse got=%0h exp=0", flush_done); end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_saturation();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
